// File: rtl/tone_driver.sv
// tone_driver
// Turns two tone frequencies (Hz) into square waves of selectable volume
// and streams them to a CS4344-class I2S DAC as 16-bit two's-complement
// frames.
//
// Ports
//   clk         system clock (100 MHz)
//   rst         synchronous, active-high reset
//   freqL/R     requested tone frequency in Hz. Out-of-range values silence
//               the channel.
//   volume      0 = silent, 1..7 = amplitude 0x0080 << volume
//   mute        forces both samples to zero while high
//   audio_mclk  DAC master clock, clk/4
//   audio_lrck  word select, clk/1024 (0 = left half-frame)
//   audio_sck   bit clock, clk/16
//   audio_sdin  serial data, updated on sck falling edges
module tone_driver #(
    parameter int unsigned HALF_CLK = 50000000,
    parameter int unsigned MIN_HZ   = 20,
    parameter int unsigned MAX_HZ   = 20000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] freqL,
    input  logic [31:0] freqR,
    input  logic [2:0]  volume,
    input  logic        mute,
    output logic        audio_mclk,
    output logic        audio_lrck,
    output logic        audio_sck,
    output logic        audio_sdin
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } div_state_t;

    // Index 0 is the left channel, index 1 the right channel.
    logic [9:0]        cnt_r;
    logic              sdin_r;
    logic [1:0][15:0]  hold_r;
    div_state_t [1:0]  state_r;
    logic [1:0][31:0]  latched_r;
    logic [1:0][31:0]  rem_r;
    logic [1:0][31:0]  quot_r;
    logic [1:0][4:0]   iter_r;
    logic [1:0][31:0]  limit_r;
    logic [1:0]        valid_r;
    logic [1:0][31:0]  wave_cnt_r;
    logic [1:0]        phase_r;

    logic [1:0][31:0]  freq_s;
    logic [1:0]        in_range_s;
    logic [1:0][63:0]  step_s;
    logic [1:0][15:0]  sample_s;
    logic [15:0]       amp_s;
    logic [4:0]        slot_next_s;
    logic [15:0]       word_s;
    logic [3:0]        bit_idx_s;
    logic              next_bit_s;

    // One restoring-division step: returns {remainder, quotient} after
    // shifting in the next dividend bit from the top of the quotient.
    function automatic logic [63:0] div_step(input logic [31:0] rem,
                                             input logic [31:0] quot,
                                             input logic [31:0] divisor);
        logic [32:0] shifted;
        logic [32:0] diff;
        shifted = {rem, quot[31]};
        diff    = shifted - {1'b0, divisor};
        if (shifted >= {1'b0, divisor}) begin
            div_step = {diff[31:0], quot[30:0], 1'b1};
        end else begin
            div_step = {shifted[31:0], quot[30:0], 1'b0};
        end
    endfunction

    assign freq_s = {freqR, freqL};

    // Range check, next divider step and gated sample value per channel.
    always_comb begin
        amp_s      = 16'h0080 << volume;
        in_range_s = 2'b00;
        step_s     = '0;
        sample_s   = '0;
        for (int ch = 0; ch < 2; ch++) begin
            in_range_s[ch] = (freq_s[ch] >= MIN_HZ) && (freq_s[ch] <= MAX_HZ);
            step_s[ch]     = div_step(rem_r[ch], quot_r[ch], latched_r[ch]);
            if (mute || (volume == 3'd0) || !valid_r[ch] || !in_range_s[ch]) begin
                sample_s[ch] = 16'h0000;
            end else if (phase_r[ch]) begin
                sample_s[ch] = amp_s;
            end else begin
                sample_s[ch] = 16'h0000 - amp_s;
            end
        end
    end

    // Bit for the upcoming slot. The slot number is only advanced while
    // cnt[3:0] == 15, so the half-frame select cannot flip for slots 1..16.
    // For slots 1..16 the sample bit 16-slot equals (-slot) mod 16.
    always_comb begin
        slot_next_s = cnt_r[8:4] + 5'd1;
        word_s      = cnt_r[9] ? hold_r[1] : hold_r[0];
        bit_idx_s   = 4'd0 - slot_next_s[3:0];
        if ((slot_next_s >= 5'd1) && (slot_next_s <= 5'd16)) begin
            next_bit_s = word_s[bit_idx_s];
        end else begin
            next_bit_s = 1'b0;
        end
    end

    // Frame counter, frame-start sample capture and serial data register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= 10'd0;
            sdin_r <= 1'b0;
            hold_r <= '0;
        end else begin
            cnt_r <= cnt_r + 10'd1;
            if (cnt_r == 10'd0) begin
                hold_r <= sample_s;
            end
            if (cnt_r[3:0] == 4'hF) begin
                sdin_r <= next_bit_s;
            end
        end
    end

    // Per-channel divider FSM and square-wave generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= {ST_IDLE, ST_IDLE};
            latched_r  <= '0;
            rem_r      <= '0;
            quot_r     <= '0;
            iter_r     <= '0;
            limit_r    <= '0;
            valid_r    <= 2'b00;
            wave_cnt_r <= '0;
            phase_r    <= 2'b00;
        end else begin
            for (int ch = 0; ch < 2; ch++) begin
                case (state_r[ch])
                    ST_IDLE: begin
                        // Clearing the latched value lets a later return to the
                        // same in-range frequency start a fresh division.
                        if (!in_range_s[ch]) begin
                            valid_r[ch]   <= 1'b0;
                            latched_r[ch] <= 32'd0;
                        end else if (freq_s[ch] != latched_r[ch]) begin
                            latched_r[ch] <= freq_s[ch];
                            rem_r[ch]     <= 32'd0;
                            quot_r[ch]    <= 32'(HALF_CLK);
                            iter_r[ch]    <= 5'd0;
                            state_r[ch]   <= ST_DIV;
                        end
                    end
                    ST_DIV: begin
                        rem_r[ch]  <= step_s[ch][63:32];
                        quot_r[ch] <= step_s[ch][31:0];
                        iter_r[ch] <= iter_r[ch] + 5'd1;
                        if (iter_r[ch] == 5'd31) begin
                            limit_r[ch] <= step_s[ch][31:0];
                            valid_r[ch] <= 1'b1;
                            state_r[ch] <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r[ch] <= ST_IDLE;
                    end
                endcase

                // The >= compare lets a shrinking limit wrap at once.
                if (!valid_r[ch]) begin
                    wave_cnt_r[ch] <= 32'd0;
                end else if (wave_cnt_r[ch] >= (limit_r[ch] - 32'd1)) begin
                    wave_cnt_r[ch] <= 32'd0;
                    phase_r[ch]    <= ~phase_r[ch];
                end else begin
                    wave_cnt_r[ch] <= wave_cnt_r[ch] + 32'd1;
                end
            end
        end
    end

    assign audio_mclk = cnt_r[1];
    assign audio_sck  = cnt_r[3];
    assign audio_lrck = cnt_r[9];
    assign audio_sdin = sdin_r;

endmodule
